// File: rtl/byte_sram_ws.sv
// rtl/byte_sram_ws.sv - byte-lane SRAM with programmable wait states and write-through read merge
module byte_sram_ws #(
  parameter int ADDR_W      = 16,
  parameter int DATA_BYTES  = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic [DATA_BYTES-1:0]   we,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [8*DATA_BYTES-1:0] wdata,
  output logic                    ready,
  output logic                    rvalid,
  output logic [8*DATA_BYTES-1:0] rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_BYTES-1:0]   we_q, we_d;
  logic [8*DATA_BYTES-1:0] wdata_q, wdata_d;
  logic                    rvalid_q, rvalid_d;
  logic [8*DATA_BYTES-1:0] rdata_q, rdata_d;

  // Storage is deliberately left out of reset; contents survive rst_n.
  logic [7:0]              mem [2**ADDR_W];

  logic                    do_access;
  logic [ADDR_W-1:0]       lane_addr [DATA_BYTES];

  // Per-lane byte address; the natural ADDR_W-bit overflow gives the wrap to byte 0.
  always_comb begin
    for (int i = 0; i < DATA_BYTES; i++) begin
      lane_addr[i] = addr_q + ADDR_W'(i);
    end
  end

  assign do_access = (state_q == BUSY) && (cnt_q == 4'd0);

  // Next-state, request capture, wait countdown and merged read result.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Written lanes return the new data; others return the stored byte.
          for (int i = 0; i < DATA_BYTES; i++) begin
            rdata_d[8*i +: 8] = we_q[i] ? wdata_q[8*i +: 8] : mem[lane_addr[i]];
          end
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers; reset clears everything except the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      we_q     <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Byte writes at the access edge; a reset in flight suppresses them.
  always_ff @(posedge clk) begin
    if (rst_n && do_access) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (we_q[i]) begin
          mem[lane_addr[i]] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign ready  = (state_q == IDLE);
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_byte_sram_ws.sv
// tb/tb_byte_sram_ws.sv - scoreboard bench for byte_sram_ws (wait-state 2 and wait-state 0 instances)
module tb_byte_sram_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_req, b_req;
  logic [3:0]  a_we, b_we;
  logic [15:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_ready, a_rvalid, b_ready, b_rvalid;
  logic [31:0] a_rdata, b_rdata;

  byte_sram_ws #(.ADDR_W(16), .DATA_BYTES(4), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
    .ready(a_ready), .rvalid(a_rvalid), .rdata(a_rdata)
  );

  byte_sram_ws #(.ADDR_W(16), .DATA_BYTES(4), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .ready(b_ready), .rvalid(b_rvalid), .rdata(b_rdata)
  );

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
  } sb_t;

  sb_t qa[$];
  sb_t qb[$];
  int  vectors = 0;
  int  errors  = 0;
  int  cyc     = 0;
  int  acc_a   = 0;
  int  acc_b   = 0;
  logic b_prev_rvalid = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
    vectors++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req_v);
    end
  endtask

  // Cycle counter and acceptance timestamps (pre-edge values are sampled here).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && a_ready && a_req) acc_a = cyc;
    if (rst_n && b_ready && b_req) acc_b = cyc;
  end

  // Monitor for instance A: data and latency of every completion.
  always @(negedge clk) begin
    sb_t e;
    if (a_rvalid) begin
      if (qa.size() == 0) begin
        chk("a_spurious_rvalid", a_rvalid, 1'b0);
      end else begin
        e = qa.pop_front();
        chk("a_rdata", a_rdata & e.mask, e.exp & e.mask);
        chk("a_latency", 64'(cyc - acc_a + 1), 64'd4);
      end
    end
  end

  // Monitor for instance B: data, latency and single-cycle rvalid width.
  always @(negedge clk) begin
    sb_t e;
    if (b_rvalid) begin
      chk("b_rvalid_width", b_prev_rvalid, 1'b0);
      if (qb.size() == 0) begin
        chk("b_spurious_rvalid", b_rvalid, 1'b0);
      end else begin
        e = qb.pop_front();
        chk("b_rdata", b_rdata & e.mask, e.exp & e.mask);
        chk("b_latency", 64'(cyc - acc_b + 1), 64'd2);
      end
    end
    b_prev_rvalid = b_rvalid;
  end

  task automatic acc_a_t(input logic [15:0] ad, input logic [3:0] w, input logic [31:0] wd,
                         input logic [31:0] ex, input logic [31:0] mk, input bit push);
    int t = 0;
    @(negedge clk);
    while (!a_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!a_ready) chk("a_ready_timeout", a_ready, 1'b1);
    a_req = 1'b1; a_addr = ad; a_we = w; a_wdata = wd;
    if (push) qa.push_back('{ex, mk});
    @(negedge clk);
    // Scrambled inputs while BUSY must have no effect.
    a_req = 1'b1; a_addr = ~ad; a_we = ~w; a_wdata = ~wd;
    #1 a_req = 1'b0;
  endtask

  task automatic acc_b_t(input logic [15:0] ad, input logic [3:0] w, input logic [31:0] wd,
                         input logic [31:0] ex);
    int t = 0;
    @(negedge clk);
    while (!b_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!b_ready) chk("b_ready_timeout", b_ready, 1'b1);
    b_req = 1'b1; b_addr = ad; b_we = w; b_wdata = wd;
    qb.push_back('{ex, 32'hFFFF_FFFF});
    @(negedge clk);
    b_req = 1'b0; b_addr = ~ad; b_we = ~w; b_wdata = ~wd;
  endtask

  task automatic drain();
    int t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_outstanding", 64'(qa.size() + qb.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = '0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", a_ready, 1'b1);
    chk("reset_rvalid", a_rvalid, 1'b0);
    chk("reset_rdata", a_rdata, 32'h0);
    rst_n = 1'b1;

    // Full write then read, plus unaligned read seeing byte 0x0010 in lane 3.
    acc_a_t(16'h0010, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFF_FFFF, 1'b1);
    acc_a_t(16'h0010, 4'h0, 32'h0,        32'hDEADBEEF, 32'hFFFF_FFFF, 1'b1);
    acc_a_t(16'h0010, 4'h0, 32'h0,        32'h000000EF, 32'h0000_00FF, 1'b1);
    acc_a_t(16'h000D, 4'h0, 32'h0,        32'hEF000000, 32'hFF00_0000, 1'b1);
    // Partial write merge.
    acc_a_t(16'h0020, 4'hF, 32'h11223344, 32'h11223344, 32'hFFFF_FFFF, 1'b1);
    acc_a_t(16'h0020, 4'h5, 32'hAABBCCDD, 32'h11BB33DD, 32'hFFFF_FFFF, 1'b1);
    acc_a_t(16'h0020, 4'h0, 32'h0,        32'h11BB33DD, 32'hFFFF_FFFF, 1'b1);
    // Address wrap across the top of memory.
    acc_a_t(16'hFFFE, 4'hF, 32'h04030201, 32'h04030201, 32'hFFFF_FFFF, 1'b1);
    acc_a_t(16'h0000, 4'h0, 32'h0,        32'h00000403, 32'h0000_FFFF, 1'b1);
    acc_a_t(16'hFFFF, 4'h0, 32'h0,        32'h00040302, 32'h00FF_FFFF, 1'b1);
    acc_a_t(16'hFFFE, 4'h0, 32'h0,        32'h04030201, 32'hFFFF_FFFF, 1'b1);
    // Reset mid-operation: preload, leave rdata nonzero, then abort a write.
    acc_a_t(16'h0040, 4'hF, 32'h00000000, 32'h00000000, 32'hFFFF_FFFF, 1'b1);
    acc_a_t(16'h0010, 4'h0, 32'h0,        32'hDEADBEEF, 32'hFFFF_FFFF, 1'b1);
    drain();
    acc_a_t(16'h0040, 4'hF, 32'h55555555, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", a_ready, 1'b1);
    chk("abort_rvalid", a_rvalid, 1'b0);
    chk("abort_rdata", a_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    acc_a_t(16'h0040, 4'h0, 32'h0, 32'h00000000, 32'hFFFF_FFFF, 1'b1);
    drain();

    // Zero-wait instance: preload, then back-to-back reads with busy-cycle address changes.
    acc_b_t(16'h0000, 4'hF, 32'h03020100, 32'h03020100);
    acc_b_t(16'h0004, 4'hF, 32'h07060504, 32'h07060504);
    acc_b_t(16'h0008, 4'hF, 32'h0B0A0908, 32'h0B0A0908);
    drain();
    @(negedge clk);
    chk("b2b_ready0", b_ready, 1'b1);
    b_req = 1'b1; b_we = 4'h0; b_addr = 16'h0000; b_wdata = 32'hFFFF_FFFF;
    qb.push_back('{32'h03020100, 32'hFFFF_FFFF});
    qb.push_back('{32'h07060504, 32'hFFFF_FFFF});
    @(negedge clk);
    chk("b2b_busy1", b_ready, 1'b0);
    b_addr = 16'h0008; b_we = 4'hF;
    @(negedge clk);
    chk("b2b_ready2", b_ready, 1'b1);
    b_addr = 16'h0004; b_we = 4'h0;
    @(negedge clk);
    chk("b2b_busy3", b_ready, 1'b0);
    b_addr = 16'h0008; b_we = 4'hF;
    @(negedge clk);
    chk("b2b_ready4", b_ready, 1'b1);
    b_req = 1'b0; b_we = 4'h0;
    drain();
    // Confirm busy-cycle writes to 0x0008 never landed.
    acc_b_t(16'h0008, 4'h0, 32'h0, 32'h0B0A0908);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
